temp_sensor_monitor: RTL and testbench



---
 rtl/temp_sensor_monitor_pkg.sv | 25 ++
 rtl/temp_edge_sync.sv | 32 +++
 rtl/temp_sensor_monitor.sv | 158 +++++++++++++++
 tb/tb_temp_sensor_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sensor_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | temp_sensor_monitor_pkg: shared constants and FSM state type for the      |
// | ring-oscillator temperature monitors.                                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package temp_sensor_monitor_pkg;

  // params
  localparam int TEMP_CNT_WIDTH     = 14;
  localparam int TEMP_WINDOW_CYCLES = 4096;
  localparam int TEMP_FAIL_LIMIT    = 2;
  localparam int TEMP_PASS_LIMIT    = 4;
  localparam int TEMP_SYNC_CYCLES   = 3;

  // le_types
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    COUNT = 2'd2,
    EVAL  = 2'd3
  } temp_mon_state_t;

endpackage
`default_nettype wire

// File: rtl/temp_edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | temp_edge_sync: 2-FF synchronizer plus edge-detect FF; pulses one cycle   |
// | for each rising edge of the asynchronous input.                           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module temp_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule
`default_nettype wire

// File: rtl/temp_sensor_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | temp_sensor_monitor: counts ring-oscillator edges per window, compares    |
// | to threshold and drives a debounced good flag with hysteresis.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module temp_sensor_monitor
  import temp_sensor_monitor_pkg::*;
#(
  parameter int CNT_WIDTH     = TEMP_CNT_WIDTH,
  parameter int WINDOW_CYCLES = TEMP_WINDOW_CYCLES,
  parameter int FAIL_LIMIT    = TEMP_FAIL_LIMIT,
  parameter int PASS_LIMIT    = TEMP_PASS_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 ro_clk_i,
  input  logic [CNT_WIDTH-1:0] threshold_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 count_valid_o,
  output logic                 good_o
);

  localparam int CYC_W  = $clog2(WINDOW_CYCLES);
  localparam int PASS_W = $clog2(PASS_LIMIT + 1);
  localparam int FAIL_W = $clog2(FAIL_LIMIT + 1);

  localparam logic [CYC_W-1:0]     LAST_CYC  = CYC_W'(WINDOW_CYCLES - 1);
  localparam logic [CYC_W-1:0]     SYNC_LAST = CYC_W'(TEMP_SYNC_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [PASS_W-1:0]    PASS_MAX  = PASS_W'(PASS_LIMIT);
  localparam logic [FAIL_W-1:0]    FAIL_MAX  = FAIL_W'(FAIL_LIMIT);

  temp_mon_state_t      state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 valid_q, valid_d;
  logic                 good_q, good_d;
  logic [PASS_W-1:0]    pass_q, pass_d;
  logic [FAIL_W-1:0]    fail_q, fail_d;
  logic                 ro_edge;

  temp_edge_sync u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(ro_clk_i),
    .edge_o (ro_edge)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    edge_cnt_d = edge_cnt_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    good_d     = good_q;
    pass_d     = pass_q;
    fail_d     = fail_q;

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = SYNC;
          cyc_d   = '0;
        end
      end

      SYNC: begin
        if (!enable_i) begin
          state_d = IDLE;
          pass_d  = '0;
          fail_d  = '0;
        end else if (cyc_q == SYNC_LAST) begin
          state_d    = COUNT;
          cyc_d      = '0;
          edge_cnt_d = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      COUNT: begin
        if (ro_edge && (edge_cnt_q != CNT_MAX)) begin
          edge_cnt_d = edge_cnt_q + 1'b1;
        end
        // Aborted windows leave count/good untouched but restart both streaks.
        if (!enable_i) begin
          state_d = IDLE;
          pass_d  = '0;
          fail_d  = '0;
        end else if (cyc_q == LAST_CYC) begin
          state_d = EVAL;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end

      EVAL: begin
        valid_d = 1'b1;
        count_d = edge_cnt_q;
        if (edge_cnt_q >= threshold_i) begin
          fail_d = '0;
          pass_d = (pass_q == PASS_MAX) ? pass_q : pass_q + 1'b1;
          if (pass_d == PASS_MAX) begin
            good_d = 1'b1;
          end
        end else begin
          pass_d = '0;
          fail_d = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;
          if (fail_d == FAIL_MAX) begin
            good_d = 1'b0;
          end
        end
        if (enable_i) begin
          state_d    = COUNT;
          cyc_d      = '0;
          edge_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      edge_cnt_q <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      good_q     <= 1'b0;
      pass_q     <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      edge_cnt_q <= edge_cnt_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      good_q     <= good_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  assign count_o       = count_q;
  assign count_valid_o = valid_q;
  assign good_o        = good_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_sensor_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_temp_sensor_monitor: directed + randomized bench with a window-level   |
// | reference model for count, pulse timing and good-flag hysteresis.         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_temp_sensor_monitor;

  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        ro = 1'b0;
  logic        ro2 = 1'b0;
  logic [13:0] threshold;
  logic [3:0]  threshold2;
  logic [13:0] count1;
  logic        valid1;
  logic        good1;
  logic [3:0]  count2;
  logic        valid2;
  logic        good2;

  int compared = 0;
  int failed   = 0;
  int ro_half  = 40;

  // Reference model state: outcome history since the last restart.
  bit hist[$];
  bit m_good;
  int m_count;
  int m2_n;
  bit m2_good;
  bit fresh;
  int prev_div;

  temp_sensor_monitor #(
    .CNT_WIDTH(14), .WINDOW_CYCLES(W), .FAIL_LIMIT(2), .PASS_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .ro_clk_i(ro),
    .threshold_i(threshold), .count_o(count1), .count_valid_o(valid1), .good_o(good1)
  );

  temp_sensor_monitor #(
    .CNT_WIDTH(4), .WINDOW_CYCLES(W), .FAIL_LIMIT(2), .PASS_LIMIT(4)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .ro_clk_i(ro2),
    .threshold_i(threshold2), .count_o(count2), .count_valid_o(valid2), .good_o(good2)
  );

  always #5 clk = ~clk;

  // Oscillator edges are offset from clk edges so sampling is never racy.
  initial begin
    #3;
    forever begin
      #(ro_half) ro = ~ro;
    end
  end

  initial begin
    #2;
    forever begin
      #10 ro2 = ~ro2;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
    compared++;
    assert (obs >= lo && obs <= hi) else begin
      failed++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic void model_step(input bit passed);
    hist.push_back(passed);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() == 4 && hist[0] && hist[1] && hist[2] && hist[3]) m_good = 1'b1;
    else if (hist.size() >= 2 && !hist[hist.size()-1] && !hist[hist.size()-2]) m_good = 1'b0;
  endfunction

  // Plausible count range for a window at clk/div, widened after a rate change or restart.
  task automatic count_range(input int div, output int lo, output int hi);
    int nom;
    nom = W / div;
    if (div != prev_div) begin
      lo = (div == 8) ? 6 : 3;
      hi = (div == 8) ? 9 : 5;
    end else if (fresh) begin
      lo = nom - 1;
      hi = nom + 1;
    end else begin
      lo = nom;
      hi = nom;
    end
  endtask

  function automatic logic [13:0] pick_thr(input int lo, input int hi);
    int r;
    logic [13:0] t;
    r = $urandom_range(0, 7);
    if (r == 0) return 14'd0;
    if (r == 1) return 14'h3FFF;
    t = 14'($urandom_range(0, 15));
    while (t > lo && t <= hi) t = 14'($urandom_range(0, 15));
    return t;
  endfunction

  task automatic wait_pulse(input int limit, output int n);
    for (n = 1; n <= limit; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid1 === 1'b1) break;
      check("good_hold", good1, m_good);
      check("valid2_idle", valid2, 0);
      check("good2_hold", good2, m2_good);
      if (m_count >= 0) check("count_hold", count1, m_count);
    end
    check("pulse_seen", valid1, 1);
  endtask

  task automatic run_window(input int div, input logic [13:0] thr);
    int  lo, hi, n;
    bit  passed;
    count_range(div, lo, hi);
    ro_half   = div * 5;
    threshold = thr;
    wait_pulse(100, n);
    check("period", n, fresh ? 69 : 65);
    check_range("count", count1, lo, hi);
    passed = (thr <= lo);
    model_step(passed);
    m_count = (lo == hi) ? lo : -1;
    check("good", good1, m_good);
    check("valid2", valid2, 1);
    check("count2_sat", count2, 15);
    m2_n++;
    if (m2_n >= 4) m2_good = 1'b1;
    check("good2", good2, m2_good);
    prev_div = div;
    fresh    = 1'b0;
  endtask

  initial begin
    int          lo, hi, div;
    logic [13:0] thr;

    rst_n      = 1'b0;
    enable     = 1'b0;
    threshold  = 14'd6;
    threshold2 = 4'hF;
    m_good     = 1'b0;
    m_count    = 0;
    m2_n       = 0;
    m2_good    = 1'b0;
    fresh      = 1'b1;
    prev_div   = 8;

    repeat (3) @(negedge clk);
    check("rst_count", count1, 0);
    check("rst_valid", valid1, 0);
    check("rst_good", good1, 0);
    check("rst_count2", count2, 0);
    check("rst_valid2", valid2, 0);
    check("rst_good2", good2, 0);

    rst_n  = 1'b1;
    enable = 1'b1;

    // Qualify: good rises exactly at the 4th pulse.
    repeat (4) run_window(8, 14'd6);
    // Two failing windows: holds at the first, falls at the second.
    repeat (2) run_window(16, 14'd6);
    // Alternating outcomes while bad never rise.
    for (int i = 0; i < 6; i++) run_window((i % 2 == 0) ? 8 : 16, 14'd6);
    repeat (4) run_window(8, 14'd6);
    // Alternating outcomes while good never fall.
    for (int i = 0; i < 6; i++) run_window((i % 2 == 0) ? 16 : 8, 14'd6);

    for (int i = 0; i < 12; i++) begin
      div = ($urandom_range(0, 1) == 0) ? 8 : 16;
      count_range(div, lo, hi);
      thr = pick_thr(lo, hi);
      run_window(div, thr);
    end

    // Abort a partially built pass streak from the bad state.
    repeat (2) run_window(16, 14'd6);
    repeat (3) run_window(8, 14'd6);
    threshold = 14'd6;
    repeat (30) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    hist.delete();
    m2_n = 0;
    repeat (12) begin
      @(negedge clk);
      check("abort_no_pulse", valid1, 0);
      check("abort_good_hold", good1, m_good);
      check("abort_count_hold", count1, m_count);
      check("abort_no_pulse2", valid2, 0);
    end
    enable = 1'b1;
    fresh  = 1'b1;
    repeat (4) run_window(8, 14'd6);

    // Asynchronous reset in the middle of a window while good.
    threshold = 14'd6;
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", count1, 0);
    check("async_rst_valid", valid1, 0);
    check("async_rst_good", good1, 0);
    check("async_rst_count2", count2, 0);
    check("async_rst_good2", good2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    m_good  = 1'b0;
    m_count = 0;
    m2_n    = 0;
    m2_good = 1'b0;
    fresh   = 1'b1;
    repeat (2) run_window(8, 14'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
`default_nettype wire
